// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int TIMER_W    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF/D) and memory-side handshake bundle of the arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_err;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic [DATA_W-1:0]   d_rdata;
  logic                d_done;
  logic                d_err;

  logic                mem_valid;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic                mem_ready;
  logic [DATA_W-1:0]   mem_rdata;
  logic                busy;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    output if_rdata, if_done, if_err, d_rdata, d_done, d_err,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    input  if_rdata, if_done, if_err, d_rdata, d_done, d_err,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_be, busy
  );
endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// Wait-state counter; expire flags the no-ready cycle whose increment reaches TIMEOUT.
module mem_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  // Firing one cycle early keeps mem_valid high for exactly TIMEOUT cycles.
  assign expire = en && (count == LAST);
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one registered memory port between IF and D.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);
  state_t state;
  gnt_t   rrLast;
  logic   maskVld;
  logic   expire;

  logic                ifReqEff, dReqEff, pickD, nxtWe;
  logic [ADDR_W-1:0]   nxtAddr;
  logic [DATA_W-1:0]   nxtWdata;
  logic [DATA_W/8-1:0] nxtBe;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) uTimer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == IDLE),
    .en     ((state == ACCESS) && !bus.mem_ready),
    .expire (expire)
  );

  // rrLast doubles as the masked id: it is the requester just served.
  always_comb begin
    ifReqEff = bus.if_req && !(maskVld && rrLast == GNT_IF);
    dReqEff  = bus.d_req  && !(maskVld && rrLast == GNT_D);
    pickD    = dReqEff && (!ifReqEff || rrLast == GNT_IF);
    nxtWe    = pickD && bus.d_we;
    nxtAddr  = pickD ? bus.d_addr : bus.if_addr;
    nxtWdata = pickD ? bus.d_wdata : '0;
    nxtBe    = nxtWe ? bus.d_be : '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rrLast        <= GNT_D;
      maskVld       <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      bus.if_rdata  <= '0;
      bus.if_done   <= 1'b0;
      bus.if_err    <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_done    <= 1'b0;
      bus.d_err     <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.if_done <= 1'b0;
      bus.if_err  <= 1'b0;
      bus.d_done  <= 1'b0;
      bus.d_err   <= 1'b0;
      maskVld     <= 1'b0;
      case (state)
        IDLE: begin
          if (ifReqEff || dReqEff) begin
            rrLast        <= pickD ? GNT_D : GNT_IF;
            bus.mem_valid <= 1'b1;
            bus.mem_we    <= nxtWe;
            bus.mem_addr  <= nxtAddr;
            bus.mem_wdata <= nxtWdata;
            bus.mem_be    <= nxtBe;
            bus.busy      <= 1'b1;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (bus.mem_ready || expire) begin
            bus.mem_valid <= 1'b0;
            state         <= RESP;
            if (rrLast == GNT_IF) begin
              bus.if_done  <= 1'b1;
              bus.if_err   <= !bus.mem_ready;
              bus.if_rdata <= bus.mem_ready ? bus.mem_rdata : '0;
            end else begin
              bus.d_done <= 1'b1;
              bus.d_err  <= !bus.mem_ready;
              if (!bus.mem_we) bus.d_rdata <= bus.mem_ready ? bus.mem_rdata : '0;
            end
          end
        end
        RESP: begin
          maskVld  <= 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; samples 1 time unit after each rising edge.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nChk  = 0;
  int nFail = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_be      = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idleInputs();
    tick(); tick();
    nChk++; if (bus.mem_valid !== 1'b0) begin nFail++; $display("FAIL reset_mem_valid: got %0b want 0", bus.mem_valid); end
    nChk++; if (bus.busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    nChk++; if ({bus.if_done, bus.d_done, bus.if_err, bus.d_err} !== 4'b0) begin nFail++; $display("FAIL reset_done_err: got %b want 0000", {bus.if_done, bus.d_done, bus.if_err, bus.d_err}); end
    nChk++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== '0) begin nFail++; $display("FAIL reset_mem_regs: got nonzero"); end
    nChk++; if ({bus.if_rdata, bus.d_rdata} !== 64'h0) begin nFail++; $display("FAIL reset_rdata: got %h want 0", {bus.if_rdata, bus.d_rdata}); end
    rst = 1'b0;
  endtask

  task automatic test_single_if;
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h0100_0000;
    tick();
    nChk++; if (bus.mem_valid !== 1'b1) begin nFail++; $display("FAIL if_mem_valid: got %0b want 1", bus.mem_valid); end
    nChk++; if (bus.mem_addr !== 32'h0100_0000) begin nFail++; $display("FAIL if_mem_addr: got %h want 01000000", bus.mem_addr); end
    nChk++; if ({bus.mem_we, bus.mem_be} !== 5'b0_1111) begin nFail++; $display("FAIL if_we_be: got %b want 01111", {bus.mem_we, bus.mem_be}); end
    nChk++; if (bus.if_done !== 1'b0) begin nFail++; $display("FAIL if_done_early: got %0b want 0", bus.if_done); end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0013;
    tick();
    nChk++; if ({bus.if_done, bus.if_err, bus.d_done} !== 3'b100) begin nFail++; $display("FAIL if_done: got %b want 100", {bus.if_done, bus.if_err, bus.d_done}); end
    nChk++; if (bus.if_rdata !== 32'h13) begin nFail++; $display("FAIL if_rdata: got %h want 00000013", bus.if_rdata); end
    nChk++; if (bus.mem_valid !== 1'b0) begin nFail++; $display("FAIL if_valid_drop: got %0b want 0", bus.mem_valid); end
    idleInputs();
    tick();
    nChk++; if ({bus.if_done, bus.busy} !== 2'b00) begin nFail++; $display("FAIL if_done_pulse: got %b want 00", {bus.if_done, bus.busy}); end
  endtask

  task automatic test_mask;
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_1000;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0AAA;
    tick();  // c1 access
    tick();  // c2 resp
    nChk++; if (bus.if_done !== 1'b1) begin nFail++; $display("FAIL mask_done: got %0b want 1", bus.if_done); end
    tick();  // c3 masked idle
    tick();  // c4 idle, grant sampled here
    nChk++; if (bus.mem_valid !== 1'b0) begin nFail++; $display("FAIL mask_regrant: got mem_valid %0b want 0", bus.mem_valid); end
    tick();  // c5 access again
    nChk++; if (bus.mem_valid !== 1'b1) begin nFail++; $display("FAIL mask_release: got mem_valid %0b want 1", bus.mem_valid); end
    tick();
    idleInputs();
    tick();
  endtask

  task automatic test_load;
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0200;
    bus.d_be = 4'b0000; bus.d_wdata = 32'h1111_2222;
    tick();
    nChk++; if ({bus.mem_valid, bus.mem_we, bus.mem_be} !== 6'b10_1111) begin nFail++; $display("FAIL load_req: got %b want 101111", {bus.mem_valid, bus.mem_we, bus.mem_be}); end
    nChk++; if (bus.mem_addr !== 32'h200) begin nFail++; $display("FAIL load_addr: got %h want 00000200", bus.mem_addr); end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    tick();
    nChk++; if ({bus.d_done, bus.d_err, bus.if_done} !== 3'b100) begin nFail++; $display("FAIL load_done: got %b want 100", {bus.d_done, bus.d_err, bus.if_done}); end
    nChk++; if (bus.d_rdata !== 32'hCAFE_F00D) begin nFail++; $display("FAIL load_rdata: got %h want cafef00d", bus.d_rdata); end
    idleInputs();
    tick();
    nChk++; if (bus.d_done !== 1'b0) begin nFail++; $display("FAIL load_pulse: got %0b want 0", bus.d_done); end
  endtask

  task automatic test_store;
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0000_0040;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_be = 4'b0011;
    for (int c = 1; c <= 3; c++) begin
      tick();
      nChk++;
      if ({bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {2'b11, 32'h40, 32'hDEAD_BEEF, 4'b0011}) begin
        nFail++; $display("FAIL store_stable c%0d: got v%0b we%0b a%h d%h be%b want v1 we1 a00000040 ddeadbeef be0011",
                          c, bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
      end
      nChk++; if (bus.d_done !== 1'b0) begin nFail++; $display("FAIL store_done_early c%0d: got %0b want 0", c, bus.d_done); end
      if (c == 3) begin bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678; end
    end
    tick();
    nChk++; if ({bus.d_done, bus.d_err, bus.mem_valid} !== 3'b100) begin nFail++; $display("FAIL store_done: got %b want 100", {bus.d_done, bus.d_err, bus.mem_valid}); end
    nChk++; if (bus.d_rdata !== 32'hCAFE_F00D) begin nFail++; $display("FAIL store_rdata_kept: got %h want cafef00d", bus.d_rdata); end
    idleInputs();
    tick();
  endtask

  task automatic test_tie;
    rst = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h0100_0004;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0300;
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h55AA_0001;
    tick();
    rst = 1'b0;
    tick();  // c1
    nChk++; if (bus.mem_addr !== 32'h0100_0004) begin nFail++; $display("FAIL tie_first_if: got addr %h want 01000004", bus.mem_addr); end
    tick();  // c2
    nChk++; if ({bus.if_done, bus.d_done} !== 2'b10) begin nFail++; $display("FAIL tie_if_done: got %b want 10", {bus.if_done, bus.d_done}); end
    tick();  // c3 masked idle
    tick();  // c4
    nChk++; if ({bus.mem_valid, bus.mem_addr} !== {1'b1, 32'h300}) begin nFail++; $display("FAIL tie_then_d: got v%0b addr %h want v1 addr 00000300", bus.mem_valid, bus.mem_addr); end
    tick();  // c5
    nChk++; if ({bus.if_done, bus.d_done} !== 2'b01) begin nFail++; $display("FAIL tie_d_done: got %b want 01", {bus.if_done, bus.d_done}); end
    nChk++; if (bus.d_rdata !== 32'h55AA_0001) begin nFail++; $display("FAIL tie_d_rdata: got %h want 55aa0001", bus.d_rdata); end
    tick(); tick();  // c6 idle, c7 access
    nChk++; if (bus.mem_addr !== 32'h0100_0004) begin nFail++; $display("FAIL tie_alternate: got addr %h want 01000004", bus.mem_addr); end
    tick();  // c8
    nChk++; if (bus.if_done !== 1'b1) begin nFail++; $display("FAIL tie_if_done2: got %0b want 1", bus.if_done); end
    idleInputs();
    tick();
  endtask

  task automatic test_timeout;
    int nValid;
    int nDone;
    int doneAt;
    logic errAt;
    logic [31:0] rdAt;
    nValid = 0; nDone = 0; doneAt = 0; errAt = 1'b0; rdAt = '1;
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0080;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (bus.mem_valid) nValid++;
      if (bus.d_done) begin nDone++; doneAt = i; errAt = bus.d_err; rdAt = bus.d_rdata; bus.d_req = 1'b0; end
    end
    nChk++; if (nValid !== 15) begin nFail++; $display("FAIL timeout_valid_cycles: got %0d want 15", nValid); end
    nChk++; if ({nDone, doneAt} !== {32'd1, 32'd16}) begin nFail++; $display("FAIL timeout_done: got %0d pulses at c%0d want 1 at c16", nDone, doneAt); end
    nChk++; if (errAt !== 1'b1) begin nFail++; $display("FAIL timeout_err: got %0b want 1", errAt); end
    nChk++; if (rdAt !== 32'h0) begin nFail++; $display("FAIL timeout_rdata: got %h want 0", rdAt); end
    idleInputs();
  endtask

  task automatic test_boundary;
    int nValid;
    int doneAt;
    logic errAt;
    logic [31:0] rdAt;
    nValid = 0; doneAt = 0; errAt = 1'b1; rdAt = '0;
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0084;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.mem_valid) nValid++;
      if (bus.d_done) begin doneAt = i; errAt = bus.d_err; rdAt = bus.d_rdata; bus.d_req = 1'b0; end
      bus.mem_ready = (i == 15);
      bus.mem_rdata = (i == 15) ? 32'hB0B0_0015 : 32'h0;
    end
    nChk++; if ({nValid, doneAt} !== {32'd15, 32'd16}) begin nFail++; $display("FAIL boundary_timing: got %0d valid, done c%0d want 15, c16", nValid, doneAt); end
    nChk++; if (errAt !== 1'b0) begin nFail++; $display("FAIL boundary_err: got %0b want 0", errAt); end
    nChk++; if (rdAt !== 32'hB0B0_0015) begin nFail++; $display("FAIL boundary_rdata: got %h want b0b00015", rdAt); end
    idleInputs();
    tick();
  endtask

  task automatic test_rst_mid;
    tick();
    bus.if_req = 1'b1; bus.if_addr = 32'h0100_0010;
    tick(); tick();
    nChk++; if (bus.mem_valid !== 1'b1) begin nFail++; $display("FAIL rstmid_access: got %0b want 1", bus.mem_valid); end
    #2 rst = 1'b1;
    #1;
    nChk++; if ({bus.mem_valid, bus.busy, bus.if_done, bus.d_done} !== 4'b0) begin nFail++; $display("FAIL rstmid_async: got %b want 0000", {bus.mem_valid, bus.busy, bus.if_done, bus.d_done}); end
    nChk++; if ({bus.mem_addr, bus.if_rdata, bus.d_rdata} !== '0) begin nFail++; $display("FAIL rstmid_regs: got addr %h if_rdata %h d_rdata %h want 0", bus.mem_addr, bus.if_rdata, bus.d_rdata); end
    tick();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_0500;
    rst = 1'b0;
    tick();
    nChk++; if ({bus.mem_valid, bus.mem_addr} !== {1'b1, 32'h0100_0010}) begin nFail++; $display("FAIL rstmid_regrant: got v%0b addr %h want v1 addr 01000010", bus.mem_valid, bus.mem_addr); end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0077;
    tick();
    nChk++; if ({bus.if_done, bus.d_done, bus.if_rdata} !== {2'b10, 32'h77}) begin nFail++; $display("FAIL rstmid_done: got if%0b d%0b rdata %h want if1 d0 00000077", bus.if_done, bus.d_done, bus.if_rdata); end
    idleInputs();
    tick(); tick();
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_single_if();
    test_mask();
    test_load();
    test_store();
    test_tie();
    test_timeout();
    test_boundary();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
